reqack_tph_src: RTL
===================

# reqack_tph_src

Transmitter end of the request–acknowledge two-phase handshake. Accepts words from local synchronous logic over a valid/ready interface, buffers them in a DEPTH-entry FIFO, and issues each word to a downstream two-phase consumer by toggling `req`. It completes when the consumer mirrors the toggle on `ack`. It sits at the head of a two-phase pipeline chain and drives the first pipe stage or an asynchronous consumer, with an optional CDC synchronizer on `ack`.

## Interface
- `DWIDTH`, 1: data path bit width.
- `DEPTH`, 2: FIFO entries. Must be a power of 2, range 2..16.
- `INCLUDE_CDC_ACK`, 1'b0: when set, `ack` passes through a 2-flop synchronizer before use. When clear, `ack` is used directly (same-clock consumer).
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `i_vld`  input  1  local word valid.
- `i_rdy`  output  1  FIFO can accept a word.
- `i_dat`  input  DWIDTH  local word.
- `req`  output  1  two-phase request. A toggle means a new word is on `o_dat`.
- `ack`  input  1  two-phase acknowledge from the consumer.
- `o_dat`  output  DWIDTH  word presented to the consumer.
- `level`  output  $clog2(DEPTH+1)  FIFO occupancy. Excludes the word currently on `o_dat`.
- `busy`  output  1  FIFO non-empty or a transfer is outstanding.
- `proto_err`  output  1  sticky protocol-violation flag.

## Operation
- `ack_i` is the synchronized `ack` (CDC on) or raw `ack` (CDC off). `ack_d` is `ack_i` registered for one cycle.
- Outstanding transfer: `req != ack_i`. Idle: `req == ack_i`.
- Push: `i_vld & i_rdy` writes `i_dat` at the write pointer and increments `level`.
- `i_rdy = (level != DEPTH)`. It is registered-state only, with no combinational path from `ack`.
- Launch condition: `launch = (req == ack_i) & (level != 0)`. On launch, at the clock edge:
  - `req <= ~req`
  - `o_dat <=` FIFO head
  - pop: read pointer increments and `level` decrements
- Push and launch in the same cycle: `level` is unchanged and both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- `o_dat` changes only on launch. It is stable while a transfer is outstanding and holds its last value while idle.
- `busy = (level != 0) | (req != ack_i)`.
- Two states, derived from `req` and `ack_i` with no explicit state register:
  - IDLE→WAIT on launch.
  - WAIT→IDLE when `ack_i` toggles to equal `req`.
  - WAIT→WAIT (back-to-back) when the ack arrives and `level != 0`, because launch is evaluated in the same cycle.
- Protocol error: `proto_err` is set when `(ack_i != ack_d) & (req == ack_d)`, i.e. `ack` toggled with nothing outstanding.
  - It stays set until reset.
  - The spurious toggle then appears as an outstanding transfer. The block waits for `ack` to return; it is not otherwise recovered.
- Reset (any time, including mid-transfer) forces the following:
  - `req=0`, `o_dat=0`, `level=0`, both pointers 0
  - `proto_err=0`, `ack_d=0`, CDC flops 0
  - buffered words are discarded
- After reset, `i_rdy=1` and `busy=0`, assuming `ack` is low.

## Timing
- Accept-to-request latency is 1 cycle. A word pushed at edge N into an empty, idle block launches at edge N+1: `req` toggles and `o_dat` is valid after edge N+1.
- Ack-to-next-request latency:
  - CDC off: `ack` seen at edge M relaunches at edge M (0 extra cycles).
  - CDC on: the launch comes 2 edges later.
- Sustained throughput, CDC off, with a consumer acking in the cycle after `req`: one word per 2 cycles.
- `i_rdy` reflects `level` after the current edge. At full, a same-cycle pop does not permit a push; `i_rdy` rises one cycle later.
- `level`, `i_rdy` and `busy` (FIFO part) are all registered. `busy` has a combinational term from `ack_i`.

## Test plan
- Reset check: assert `rst_n=0` with random inputs -> `req=0`, `o_dat=0`, `level=0`, `i_rdy=1`, `busy=0`, `proto_err=0`. Release with `ack=0` -> outputs hold.
- Single word, CDC off, DWIDTH=8: push 0xA5 at edge 0.
  - Edge 1: `req=1`, `o_dat=0xA5`, `level=0`.
  - Drive `ack=1` at cycle 4: `busy` drops in the same cycle; `proto_err=0`.
- Fill and drain, DEPTH=2, `ack` held off: push 0x11, 0x22, 0x33 back-to-back.
  - 0x11 launches; `level` reaches 2 and `i_rdy=0`.
  - Ack 0x11: 0x22 launches on the same edge, and `i_rdy` rises the next cycle.
  - All three words arrive in order, and `o_dat` is stable between toggles.
- CDC on: same single-word flow. `ack` toggle at edge M -> `busy=0` after edge M+2. A queued second word launches at edge M+2.
- Protocol error: while idle, toggle `ack` 0->1 -> `proto_err=1` one cycle later and stays 1. A following `req` toggle does not occur until `ack` returns to 0.
- Reset mid-transfer: push two words, launch the first, assert `rst_n` before `ack` -> all reset values. After release, push 0x5A -> `req` toggles 0->1 with `o_dat=0x5A`, and no stale words are issued.

Source files
------------

// File: rtl/reqack_tph_src.sv
// Two-phase req/ack transmitter: valid/ready FIFO front end,
// each buffered word issued downstream by toggling req.
module reqack_tph_src #(
  parameter int DWIDTH          = 1,
  parameter int DEPTH           = 2,
  parameter bit INCLUDE_CDC_ACK = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_vld,
  output logic                       i_rdy,
  input  logic [DWIDTH-1:0]          i_dat,
  output logic                       req,
  input  logic                       ack,
  output logic [DWIDTH-1:0]          o_dat,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       busy,
  output logic                       proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  if ((DEPTH < 2) || (DEPTH > 16) ||
      ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("reqack_tph_src: DEPTH must be a power of 2 in 2..16");
  end

  logic          ack_i;
  logic          ack_d;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          launch;

  logic [DWIDTH-1:0] mem [DEPTH];

  if (INCLUDE_CDC_ACK) begin : g_cdc
    logic s1;
    logic s2;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= ack;
        s2 <= s1;
      end
    end
    assign ack_i = s2;
  end else begin : g_raw
    assign ack_i = ack;
  end

  assign i_rdy  = (level != FULL);
  assign push   = i_vld & i_rdy;
  assign launch = (req == ack_i) & (level != '0);
  assign busy   = (level != '0) | (req != ack_i);

  // Storage holds no state that matters after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= i_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req       <= 1'b0;
      o_dat     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      ack_d     <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      ack_d <= ack_i;
      if ((ack_i != ack_d) && (req == ack_d)) begin
        proto_err <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (launch) begin
        req    <= ~req;
        o_dat  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case (1'b1)
        push & ~launch: level <= level + LW'(1);
        ~push & launch: level <= level - LW'(1);
        default:        level <= level;
      endcase
    end
  end

endmodule
